ps2_scancode_joymap: RTL and testbench

- Sits between io_ps2_keyboard and the arcade core top level.
- Consumes the raw scancode byte and its one-cycle interrupt strobe.
- Decodes PS/2 set-2 make, break (F0) and extended (E0) prefixes into a held-key bitmap driving the joystick and coin/start inputs.
- Also produces stretched control pulses for scandoubler toggle, scanline cycling and core reset.

---
 rtl/joymap_pkg.sv | 82 ++++++++
 rtl/joymap_pulse_stretch.sv | 34 +++
 rtl/ps2_scancode_joymap.sv | 126 ++++++++++++
 tb/tb_ps2_scancode_joymap.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joymap_pkg.sv
// Shared types, bit positions, scancodes and key-decode helpers for the PS/2 joystick mapper.
package joymap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } joyState_e;

   localparam int JOY_UP     = 0;
   localparam int JOY_DOWN   = 1;
   localparam int JOY_LEFT   = 2;
   localparam int JOY_RIGHT  = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_START1 = 5;
   localparam int JOY_START2 = 6;
   localparam int JOY_COIN   = 7;
   localparam int JOY_FIRE2  = 8;
   localparam int JOY_W      = 9;
   localparam int JOY_S      = 10;
   localparam int JOY_A      = 11;
   localparam int JOY_D      = 12;
   localparam int JOY_BITS   = 13;

   localparam int CTRL_SCRLK = 0;
   localparam int CTRL_F2    = 1;
   localparam int CTRL_F12   = 2;

   localparam logic [7:0] SC_E0       = 8'hE0;
   localparam logic [7:0] SC_F0       = 8'hF0;
   localparam logic [7:0] SC_SCRLK    = 8'h7E;
   localparam logic [7:0] SC_F2       = 8'h06;
   localparam logic [7:0] SC_F12      = 8'h07;
   localparam logic [7:0] SC_BAT_OK   = 8'hAA;
   localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

   // Aliased keys (fire, coin) share one bit, so a break of either alias clears it.
   function automatic logic [JOY_BITS-1:0] keyMask(input logic ext, input logic [7:0] code);
      logic [JOY_BITS-1:0] m;
      m = '0;
      if (ext) begin
         case (code)
            8'h75:   m[JOY_UP]    = 1'b1;
            8'h72:   m[JOY_DOWN]  = 1'b1;
            8'h6B:   m[JOY_LEFT]  = 1'b1;
            8'h74:   m[JOY_RIGHT] = 1'b1;
            8'h14:   m[JOY_FIRE]  = 1'b1;
            default: m = '0;
         endcase
      end else begin
         case (code)
            8'h29, 8'h14: m[JOY_FIRE]   = 1'b1;
            8'h16:        m[JOY_START1] = 1'b1;
            8'h1E:        m[JOY_START2] = 1'b1;
            8'h2E, 8'h26: m[JOY_COIN]   = 1'b1;
            8'h11:        m[JOY_FIRE2]  = 1'b1;
            8'h1D:        m[JOY_W]      = 1'b1;
            8'h1B:        m[JOY_S]      = 1'b1;
            8'h1C:        m[JOY_A]      = 1'b1;
            8'h23:        m[JOY_D]      = 1'b1;
            default:      m = '0;
         endcase
      end
      return m;
   endfunction

   function automatic logic [2:0] ctrlMask(input logic ext, input logic [7:0] code);
      logic [2:0] m;
      m = '0;
      if (!ext) begin
         case (code)
            SC_SCRLK: m[CTRL_SCRLK] = 1'b1;
            SC_F2:    m[CTRL_F2]    = 1'b1;
            SC_F12:   m[CTRL_F12]   = 1'b1;
            default:  m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/joymap_pulse_stretch.sv
// Stretches a single-cycle trigger into a LEN-cycle registered pulse; triggers while busy are dropped.
module joymap_pulse_stretch #(
   parameter int LEN   = 16,
   parameter int CNT_W = 13
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic trigger_i,
   output logic pulse_o
);

   logic             pulse_q;
   logic [CNT_W-1:0] cnt_q;

   // The counter holds the number of high cycles remaining after the current one.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else if (pulse_q) begin
         if (cnt_q == '0) begin
            pulse_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end else if (trigger_i) begin
         pulse_q <= 1'b1;
         cnt_q   <= CNT_W'(LEN - 1);
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/ps2_scancode_joymap.sv
// PS/2 set-2 scancode decoder producing a held-key joystick bitmap and stretched control pulses.
// Optional macro JOYMAP_BAT_CLEAR_EN: keyboard self-test bytes (AA/FC) in IDLE clear all held keys.
module ps2_scancode_joymap
   import joymap_pkg::*;
#(
   parameter int PULSE_LEN  = 16,
   parameter int RESET_HOLD = 4096,
   parameter int CNT_W      = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        kbdint,
   input  logic [7:0]  kbdscancode,
   output logic [12:0] joyBCPPFRLDU,
   output logic        change_scandoubler,
   output logic        change_scanlines,
   output logic        reset_out
);

   joyState_e      state_q, state_d;
   logic [12:0]    joy_q, joy_d;
   logic [2:0]     ctrlHeld_q, ctrlHeld_d;
   logic [2:0]     ctrlTrig;
   logic           doMake, doBreak, isExt, batClear;
   logic [12:0]    keyBits;
   logic [2:0]     ctrlBits;

   always_comb begin
      state_d = state_q;
      doMake  = 1'b0;
      doBreak = 1'b0;
      isExt   = 1'b0;
      if (kbdint) begin
         case (state_q)
            ST_IDLE: begin
               if (kbdscancode == SC_E0)      state_d = ST_EXT;
               else if (kbdscancode == SC_F0) state_d = ST_BRK;
               else                           doMake  = 1'b1;
            end
            ST_EXT: begin
               if (kbdscancode == SC_F0) begin
                  state_d = ST_EXT_BRK;
               end else if (kbdscancode != SC_E0) begin
                  doMake  = 1'b1;
                  isExt   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               doBreak = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               doBreak = 1'b1;
               isExt   = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign keyBits  = keyMask(isExt, kbdscancode);
   assign ctrlBits = ctrlMask(isExt, kbdscancode);

`ifdef JOYMAP_BAT_CLEAR_EN
   assign batClear = kbdint && (state_q == ST_IDLE) &&
                     ((kbdscancode == SC_BAT_OK) || (kbdscancode == SC_BAT_FAIL));
`else
   assign batClear = 1'b0;
`endif

   // Pulses fire only on a 0->1 edge of the held bit, so typematic repeats are silent.
   always_comb begin
      joy_d      = joy_q;
      ctrlHeld_d = ctrlHeld_q;
      ctrlTrig   = '0;
      if (batClear) begin
         joy_d      = '0;
         ctrlHeld_d = '0;
      end else if (doMake) begin
         joy_d      = joy_q | keyBits;
         ctrlHeld_d = ctrlHeld_q | ctrlBits;
         ctrlTrig   = ctrlBits & ~ctrlHeld_q;
      end else if (doBreak) begin
         joy_d      = joy_q & ~keyBits;
         ctrlHeld_d = ctrlHeld_q & ~ctrlBits;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         joy_q      <= '0;
         ctrlHeld_q <= '0;
      end else begin
         state_q    <= state_d;
         joy_q      <= joy_d;
         ctrlHeld_q <= ctrlHeld_d;
      end
   end

   assign joyBCPPFRLDU = joy_q;

   joymap_pulse_stretch #(.LEN(PULSE_LEN), .CNT_W(CNT_W)) uScrlk (
      .clk_i     (clk),
      .reset_i   (reset),
      .trigger_i (ctrlTrig[CTRL_SCRLK]),
      .pulse_o   (change_scandoubler)
   );

   joymap_pulse_stretch #(.LEN(PULSE_LEN), .CNT_W(CNT_W)) uF2 (
      .clk_i     (clk),
      .reset_i   (reset),
      .trigger_i (ctrlTrig[CTRL_F2]),
      .pulse_o   (change_scanlines)
   );

   joymap_pulse_stretch #(.LEN(RESET_HOLD), .CNT_W(CNT_W)) uF12 (
      .clk_i     (clk),
      .reset_i   (reset),
      .trigger_i (ctrlTrig[CTRL_F12]),
      .pulse_o   (reset_out)
   );

endmodule

// File: tb/tb_ps2_scancode_joymap.sv
// Self-checking bench for ps2_scancode_joymap: directed scenarios plus randomized scancode streams.
module tb_ps2_scancode_joymap;

   localparam int PULSE_LEN  = 16;
   localparam int RESET_HOLD = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        kbdint;
   logic [7:0]  kbdscancode;
   logic [12:0] joyBCPPFRLDU;
   logic        change_scandoubler;
   logic        change_scanlines;
   logic        reset_out;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: pending prefix flags, key bitmap, held controls, remaining pulse cycles.
   logic [12:0] mJoy;
   logic [2:0]  mHeld;
   bit          mExt, mBrk;
   int          mRemain[3];

   always #5 clk = ~clk;

   ps2_scancode_joymap #(.PULSE_LEN(PULSE_LEN), .RESET_HOLD(RESET_HOLD), .CNT_W(13)) dut (
      .clk                (clk),
      .reset              (reset),
      .kbdint             (kbdint),
      .kbdscancode        (kbdscancode),
      .joyBCPPFRLDU       (joyBCPPFRLDU),
      .change_scandoubler (change_scandoubler),
      .change_scanlines   (change_scanlines),
      .reset_out          (reset_out)
   );

   function automatic int keyBit(bit ext, logic [7:0] c);
      if (ext) begin
         case (c)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            8'h14: return 4;
            default: return -1;
         endcase
      end
      case (c)
         8'h29, 8'h14: return 4;
         8'h16: return 5;
         8'h1E: return 6;
         8'h2E, 8'h26: return 7;
         8'h11: return 8;
         8'h1D: return 9;
         8'h1B: return 10;
         8'h1C: return 11;
         8'h23: return 12;
         default: return -1;
      endcase
   endfunction

   function automatic int ctrlIdx(bit ext, logic [7:0] c);
      if (ext) return -1;
      case (c)
         8'h7E: return 0;
         8'h06: return 1;
         8'h07: return 2;
         default: return -1;
      endcase
   endfunction

   task automatic modelEdge(input bit rst, input bit strobe, input logic [7:0] c);
      bit [2:0] trig;
      int k, j;
      bit bat;
      trig = '0;
      if (rst) begin
         mJoy = '0; mHeld = '0; mExt = 0; mBrk = 0;
         for (int i = 0; i < 3; i++) mRemain[i] = 0;
         return;
      end
      if (strobe) begin
         k = keyBit(mExt, c);
         j = ctrlIdx(mExt, c);
         if (mBrk) begin
            if (k >= 0) mJoy[k] = 1'b0;
            if (j >= 0) mHeld[j] = 1'b0;
            mExt = 0; mBrk = 0;
         end else if (c == 8'hE0) begin
            mExt = 1;
         end else if (c == 8'hF0) begin
            mBrk = 1;
         end else begin
            bat = 0;
`ifdef JOYMAP_BAT_CLEAR_EN
            bat = !mExt && (c == 8'hAA || c == 8'hFC);
`endif
            if (bat) begin
               mJoy = '0; mHeld = '0;
            end else begin
               if (k >= 0) mJoy[k] = 1'b1;
               if (j >= 0) begin
                  if (!mHeld[j]) trig[j] = 1'b1;
                  mHeld[j] = 1'b1;
               end
            end
            mExt = 0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (mRemain[i] > 0) mRemain[i]--;
         else if (trig[i]) mRemain[i] = (i == 2) ? RESET_HOLD : PULSE_LEN;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs settled.
   task automatic step(input bit rst, input bit strobe, input logic [7:0] c);
      reset = rst; kbdint = strobe; kbdscancode = c;
      modelEdge(rst, strobe, c);
      @(negedge clk);
      reset = 1'b0; kbdint = 1'b0; kbdscancode = 8'h00;
   endtask

   task automatic send(input logic [7:0] c);
      step(0, 1, c);
   endtask

   task automatic test_reset;
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL reset_bitmap: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
      testsRun++;
      if ({reset_out, change_scanlines, change_scandoubler} !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL reset_pulses: got %b expected 000",
                  {reset_out, change_scanlines, change_scandoubler});
      end
   endtask

   task automatic test_press_release;
      send(8'hE0);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL prefix_only: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
      send(8'h75);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0001) begin
         testsFailed++;
         $display("[TB] FAIL up_make: got %h expected %h", joyBCPPFRLDU, 13'h0001);
      end
      send(8'hE0); send(8'hF0); send(8'h75);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL up_break: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
   endtask

   task automatic test_ext_vs_normal;
      send(8'h75);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL keypad8_ignored: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
      send(8'h1D);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0200) begin
         testsFailed++;
         $display("[TB] FAIL w_make: got %h expected %h", joyBCPPFRLDU, 13'h0200);
      end
      send(8'hF0); send(8'h1D);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL w_break: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
   endtask

   task automatic test_alias;
      send(8'h2E);
      send(8'h26);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0080) begin
         testsFailed++;
         $display("[TB] FAIL coin_make: got %h expected %h", joyBCPPFRLDU, 13'h0080);
      end
      send(8'hF0); send(8'h26);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL coin_alias_break: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
   endtask

   task automatic test_bat;
      logic [12:0] expJoy;
      send(8'h29); send(8'h16);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0030) begin
         testsFailed++;
         $display("[TB] FAIL bat_setup: got %h expected %h", joyBCPPFRLDU, 13'h0030);
      end
      send(8'hAA);
`ifdef JOYMAP_BAT_CLEAR_EN
      expJoy = 13'h0000;
`else
      expJoy = 13'h0030;
`endif
      testsRun++;
      if (joyBCPPFRLDU !== expJoy) begin
         testsFailed++;
         $display("[TB] FAIL bat_byte: got %h expected %h", joyBCPPFRLDU, expJoy);
      end
      send(8'hF0); send(8'h29); send(8'hF0); send(8'h16);
   endtask

   task automatic test_scroll_lock;
      logic [7:0] seq[8] = '{8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'hF0, 8'h7E};
      int  high, rises;
      logic prev;
      for (int pass = 0; pass < 2; pass++) begin
         high = 0; rises = 0; prev = change_scandoubler;
         for (int i = 0; i < 40; i++) begin
            if (pass == 0 && i < 16 && (i % 2) == 0) step(0, 1, seq[i / 2]);
            else if (pass == 1 && i == 0)            step(0, 1, 8'h7E);
            else if (pass == 1 && i == 2)            step(0, 1, 8'hF0);
            else if (pass == 1 && i == 4)            step(0, 1, 8'h7E);
            else                                     step(0, 0, 8'h00);
            if (change_scandoubler && !prev) rises++;
            if (change_scandoubler) high++;
            prev = change_scandoubler;
            testsRun++;
            if (change_scandoubler !== (mRemain[0] > 0)) begin
               testsFailed++;
               $display("[TB] FAIL scrlk_cycle: pass %0d cycle %0d got %b expected %b",
                        pass, i, change_scandoubler, (mRemain[0] > 0));
            end
         end
         testsRun++;
         if (high != PULSE_LEN || rises != 1) begin
            testsFailed++;
            $display("[TB] FAIL scrlk_shape: pass %0d got high=%0d rises=%0d expected high=%0d rises=1",
                     pass, high, rises, PULSE_LEN);
         end
      end
   endtask

   task automatic test_reset_pulse;
      send(8'h07);
      for (int i = 1; i < 99; i++) begin
         testsRun++;
         if (reset_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL f12_hold: cycle %0d got %b expected 1", i, reset_out);
         end
         if (i < 98) step(0, 0, 8'h00);
      end
      send(8'hE0);
      step(1, 0, 8'h00);
      testsRun++;
      if ({reset_out, joyBCPPFRLDU} !== 14'h0000) begin
         testsFailed++;
         $display("[TB] FAIL mid_pulse_reset: got ro=%b joy=%h expected ro=0 joy=0000",
                  reset_out, joyBCPPFRLDU);
      end
      send(8'h75);
      testsRun++;
      if (joyBCPPFRLDU !== 13'h0000) begin
         testsFailed++;
         $display("[TB] FAIL fsm_idle_after_reset: got %h expected %h", joyBCPPFRLDU, 13'h0000);
      end
   endtask

   task automatic test_reset_hold_len;
      int high;
      high = 0;
      for (int i = 0; i < RESET_HOLD + 20; i++) begin
         if (i == 0)      step(0, 1, 8'h07);
         else if (i == 3) step(0, 1, 8'hF0);
         else if (i == 5) step(0, 1, 8'h07);
         else if (i == 9) step(0, 1, 8'h07);
         else             step(0, 0, 8'h00);
         if (reset_out) high++;
      end
      testsRun++;
      if (high != RESET_HOLD) begin
         testsFailed++;
         $display("[TB] FAIL f12_length: got %0d cycles expected %0d", high, RESET_HOLD);
      end
   endtask

   task automatic test_random;
      logic [7:0] pool[22] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29,
                               8'h16, 8'h1E, 8'h2E, 8'h26, 8'h11, 8'h1D, 8'h1B, 8'h1C,
                               8'h23, 8'h7E, 8'h06, 8'h07, 8'hAA, 8'hFC};
      logic [7:0]  c;
      logic [15:0] expv;
      int          gap;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) == 0) c = 8'($urandom_range(0, 255));
         else c = pool[$urandom_range(0, 21)];
         gap = $urandom_range(0, 2);
         for (int g = 0; g <= gap; g++) begin
            if ($urandom_range(0, 299) == 0) step(1, g == 0, c);
            else                             step(0, g == 0, c);
            expv = {mJoy, (mRemain[2] > 0), (mRemain[1] > 0), (mRemain[0] > 0)};
            testsRun++;
            if ({joyBCPPFRLDU, reset_out, change_scanlines, change_scandoubler} !== expv) begin
               testsFailed++;
               $display("[TB] FAIL random_outputs: iter %0d got %h expected %h", n,
                        {joyBCPPFRLDU, reset_out, change_scanlines, change_scandoubler}, expv);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; kbdint = 1'b0; kbdscancode = 8'h00;
      for (int i = 0; i < 3; i++) mRemain[i] = 0;
      mJoy = '0; mHeld = '0; mExt = 0; mBrk = 0;
      @(negedge clk);
      test_reset();
      test_press_release();
      test_ext_vs_normal();
      test_alias();
      test_bat();
      test_scroll_lock();
      test_reset_pulse();
      test_reset_hold_len();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
